// File: rtl/power_pipe_if.sv
// power_pipe_if - valid/ready operand and result bundle for the power_pipe unit
//
// Purpose : groups the input handshake (in_valid/in_ready, x, mode) and the
//           output handshake (out_valid/out_ready, y) of power_pipe.
// Modports: master - sample source / result sink side (drives x, mode, in_valid, out_ready)
//           slave  - the power unit itself (drives in_ready, out_valid, y)
// Params  : W - operand width; y is 3*W bits wide.

interface power_pipe_if #(
    parameter int W = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [3*W-1:0]   y;

    modport master (
        output in_valid, x, mode, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, x, mode, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/power_pipe.sv
// power_pipe - two-stage pipelined square/cube unit with valid/ready flow control
//
// Purpose : y = x^2 (mode=0) or x^3 (mode=1), selected per sample, 2-cycle latency,
//           1 sample/cycle, results in acceptance order.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - power_pipe_if.slave (in_valid/in_ready/x/mode, out_valid/out_ready/y)
// Params  : W    - operand width; result is 3*W bits (exact, never truncated)
// Config  : POWER_SIGNED_EN - when defined, x and y are two's complement; otherwise
//           both are unsigned and zero-extended. Handshake/latency are identical.

module power_pipe #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    power_pipe_if.slave  bus
);

    // Global advance: both stages move together whenever the output slot is
    // free or being drained this cycle. A stall freezes S1 even if it is empty.
    logic en;

    // Stage 1 state
    logic [2*W-1:0] sq_q, sq_d;
    logic [W-1:0]   xd_q, xd_d;
    logic           md_q, md_d;
    logic           v1_q, v1_d;

    // Stage 2 state
    logic [3*W-1:0] y_q, y_d;
    logic           ov_q, ov_d;

    // Operands widened to the product width so a plain multiply is exact.
    // The low bits of a two's complement product do not depend on signedness,
    // so only the extension differs between builds.
    logic [2*W-1:0] x_ext;
    logic [3*W-1:0] sq_ext;
    logic [3*W-1:0] xd_ext;

`ifdef POWER_SIGNED_EN
    assign x_ext  = {{W{bus.x[W-1]}}, bus.x};
    assign sq_ext = {{W{sq_q[2*W-1]}}, sq_q};
    assign xd_ext = {{(2*W){xd_q[W-1]}}, xd_q};
`else
    assign x_ext  = {{W{1'b0}}, bus.x};
    assign sq_ext = {{W{1'b0}}, sq_q};
    assign xd_ext = {{(2*W){1'b0}}, xd_q};
`endif

    assign en = !ov_q | bus.out_ready;

    always_comb begin
        sq_d = sq_q;
        xd_d = xd_q;
        md_d = md_q;
        v1_d = v1_q;
        y_d  = y_q;
        ov_d = ov_q;
        if (en) begin
            // Data registers load unconditionally; their valid bits qualify them.
            sq_d = x_ext * x_ext;
            xd_d = bus.x;
            md_d = bus.mode;
            v1_d = bus.in_valid;
            y_d  = md_q ? (sq_ext * xd_ext) : sq_ext;
            ov_d = v1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_q <= '0;
            xd_q <= '0;
            md_q <= 1'b0;
            v1_q <= 1'b0;
            y_q  <= '0;
            ov_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
            xd_q <= xd_d;
            md_q <= md_d;
            v1_q <= v1_d;
            y_q  <= y_d;
            ov_q <= ov_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = ov_q;
    assign bus.y         = y_q;

endmodule

// File: tb/tb_power_pipe.sv
// tb/tb_power_pipe.sv - self-checking bench for power_pipe (directed + randomized)

module tb_power_pipe;

    localparam int W  = 7;
    localparam int YW = 3 * W;

    logic clk;
    logic rst;

    power_pipe_if #(.W(W)) bus ();

    power_pipe #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared;
    int mismatched;
    logic [YW-1:0] exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand's numeric value.
    function automatic logic [YW-1:0] ref_pow(input logic [W-1:0] xv, input logic m);
        longint v;
        longint r;
`ifdef POWER_SIGNED_EN
        v = longint'($signed(xv));
`else
        v = longint'(xv);
`endif
        r = m ? (v * v * v) : (v * v);
        return r[YW-1:0];
    endfunction

    // One clock: check handshake rule, score transfers, advance, hold checks.
    task automatic cycle();
        logic stall;
        logic [YW-1:0] py;
        #1;
        chk("in_ready_rule", bus.in_ready, !bus.out_valid | bus.out_ready);
        stall = bus.out_valid & !bus.out_ready;
        py    = bus.y;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else chk("y_order", bus.y, exp_q.pop_front());
        end
        if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_pow(bus.x, bus.mode));
        @(posedge clk);
        #1;
        if (stall) begin
            chk("stall_y_hold", bus.y, py);
            chk("stall_ov_hold", bus.out_valid, 1);
        end
    endtask

    task automatic run_one(input logic [W-1:0] xv, input logic m, input logic [YW-1:0] ev);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.x         = xv;
        bus.mode      = m;
        cycle();
        bus.in_valid  = 1'b0;
        chk("lat_not_early", bus.out_valid, 0);
        cycle();
        chk("lat_valid", bus.out_valid, 1);
        chk("lat_y_const", bus.y, ev);
        cycle();
    endtask

    initial begin
        logic [0:7] pat;
        logic [0:7] ov_hist;
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed value/latency checks
`ifdef POWER_SIGNED_EN
        run_one(7'h7D, 1'b1, 21'h1FFFE5);
        run_one(7'h7D, 1'b0, 21'd9);
        run_one(7'h40, 1'b1, 21'h1C0000);
`else
        run_one(7'd5,   1'b1, 21'd125);
        run_one(7'd127, 1'b1, 21'd2048383);
        run_one(7'd127, 1'b0, 21'd16129);
`endif

        // Back-to-back stream x=1..10, mode alternating 1/0
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = (i < 10);
            bus.x        = W'(i + 1);
            bus.mode     = (i % 2 == 0);
            if (i >= 2) chk("stream_continuous", bus.out_valid, 1);
            cycle();
        end

        // Backpressure with a full pipe
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.x    = W'(20 + i);
            bus.mode = i[0];
            cycle();
        end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.x = W'(40 + i);
            #1;
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            #1;
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
        chk("bp_drain_empty", exp_q.size(), 0);
        cycle();

        // Reset mid-stream with two samples in flight
        bus.in_valid = 1'b1;
        bus.x = 7'd3; bus.mode = 1'b1; cycle();
        bus.x = 7'd4; bus.mode = 1'b0; cycle();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_y", bus.y, 0);
        exp_q.delete();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("midrst_no_stale", bus.out_valid, 0);
        end

        // in_valid gap pattern 1,0,0,1
        pat = 8'b1001_0000;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = pat[i];
            bus.x        = W'($urandom);
            bus.mode     = 1'($urandom);
            ov_hist[i]   = bus.out_valid;
            cycle();
        end
        for (int i = 0; i < 4; i++) chk("gap_pattern", ov_hist[i+2], pat[i]);

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.x         = W'($urandom);
            bus.mode      = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
        chk("final_drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
